song_sequencer: RTL and testbench

Note-sourcing stage directly upstream of the tone generator and 7-segment driver in the FPGA piano. It selects between free play (switches), auto-play of a stored song (Ode to Joy or Do-Re-Mi), and learn mode, where the player must press each stored note in turn. Its output is a 4-bit note code that the tone generator turns into FREQ, plus a one-hot LED hint and a step index for the display.

---
 rtl/piano_pkg.sv | 104 ++++++++++
 rtl/btn_edge.sv | 18 +
 rtl/song_sequencer.sv | 172 +++++++++++++++++
 tb/tb_song_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared note codes, FSM encoding, song ROMs and key/LED helpers for the piano
// note-sourcing stage.
package piano_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C    = 4'd1;
   localparam logic [3:0] NOTE_D    = 4'd2;
   localparam logic [3:0] NOTE_E    = 4'd3;
   localparam logic [3:0] NOTE_F    = 4'd4;
   localparam logic [3:0] NOTE_G    = 4'd5;
   localparam logic [3:0] NOTE_A    = 4'd6;
   localparam logic [3:0] NOTE_B    = 4'd7;
   localparam logic [3:0] NOTE_C2   = 4'd8;

   localparam int ODE_LEN    = 15;
   localparam int DOREMI_LEN = 7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_GAP   = 2'd2,
      S_LEARN = 2'd3
   } state_e;

   typedef enum logic {
      SONG_ODE    = 1'b0,
      SONG_DOREMI = 1'b1
   } song_e;

   function automatic int song_len(song_e song);
      return (song == SONG_ODE) ? ODE_LEN : DOREMI_LEN;
   endfunction

   // Out-of-range indices read as a rest so a stray step can never sound a note.
   function automatic logic [3:0] song_note(song_e song, int idx);
      logic [3:0] n;
      n = NOTE_REST;
      if (song == SONG_ODE) begin
         case (idx)
            0:       n = NOTE_E;
            1:       n = NOTE_E;
            2:       n = NOTE_F;
            3:       n = NOTE_G;
            4:       n = NOTE_G;
            5:       n = NOTE_F;
            6:       n = NOTE_E;
            7:       n = NOTE_D;
            8:       n = NOTE_C;
            9:       n = NOTE_C;
            10:      n = NOTE_D;
            11:      n = NOTE_E;
            12:      n = NOTE_E;
            13:      n = NOTE_D;
            14:      n = NOTE_D;
            default: n = NOTE_REST;
         endcase
      end else begin
         case (idx)
            0:       n = NOTE_C;
            1:       n = NOTE_D;
            2:       n = NOTE_E;
            3:       n = NOTE_C;
            4:       n = NOTE_E;
            5:       n = NOTE_C;
            6:       n = NOTE_E;
            default: n = NOTE_REST;
         endcase
      end
      return n;
   endfunction

   // sw[7] is the lowest key; when several keys are down, sw[7] side wins.
   function automatic logic [3:0] sw_decode(logic [7:0] sw);
      logic [3:0] n;
      n = NOTE_REST;
      if (sw[7])      n = NOTE_C;
      else if (sw[6]) n = NOTE_D;
      else if (sw[5]) n = NOTE_E;
      else if (sw[4]) n = NOTE_F;
      else if (sw[3]) n = NOTE_G;
      else if (sw[2]) n = NOTE_A;
      else if (sw[1]) n = NOTE_B;
      else if (sw[0]) n = NOTE_C2;
      return n;
   endfunction

   function automatic logic [7:0] note_onehot(logic [3:0] code);
      logic [7:0] oh;
      oh = 8'h00;
      case (code)
         NOTE_C:  oh = 8'h80;
         NOTE_D:  oh = 8'h40;
         NOTE_E:  oh = 8'h20;
         NOTE_F:  oh = 8'h10;
         NOTE_G:  oh = 8'h08;
         NOTE_A:  oh = 8'h04;
         NOTE_B:  oh = 8'h02;
         NOTE_C2: oh = 8'h01;
         default: oh = 8'h00;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a raw button level: one history flop and an AND-NOT.
module btn_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic rise_o
);

   logic hist_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) hist_q <= 1'b0;
      else       hist_q <= btn_i;
   end

   assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/song_sequencer.sv
// Note source for the tone generator: free play from switches, auto-play of a
// stored song, or learn mode where each stored note must be pressed in turn.
module song_sequencer
   import piano_pkg::*;
#(
   parameter int NOTE_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_250_000,
   parameter int IDX_W      = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ODE_TO_JOY_AUTO,
   input  logic             DOREMI_AUTO,
   input  logic             DOREMI_LEARN,
   input  logic [7:0]       sw,
   output logic [3:0]       note,
   output logic [7:0]       Led,
   output logic [IDX_W-1:0] step,
   output logic             busy,
   output logic             done,
   output logic             mistake,
   output logic [1:0]       dbg_state
);

   localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS);
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

   state_e           state_q;
   song_e            song_q;
   logic [IDX_W-1:0] step_q;
   logic [CNT_W-1:0] cnt_q;
   logic             armed_q;
   logic [3:0]       note_q;
   logic [7:0]       led_q;
   logic             done_q;
   logic             mistake_q;

   logic             ode_rise;
   logic             dra_rise;
   logic             drl_rise;
   logic [3:0]       play_note_d;
   logic [7:0]       learn_hint_d;
   logic             last_step_d;

   btn_edge u_ode_edge (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (ODE_TO_JOY_AUTO),
      .rise_o (ode_rise)
   );

   btn_edge u_dra_edge (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (DOREMI_AUTO),
      .rise_o (dra_rise)
   );

   btn_edge u_drl_edge (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (DOREMI_LEARN),
      .rise_o (drl_rise)
   );

   assign play_note_d  = song_note(song_q, int'(step_q));
   assign learn_hint_d = note_onehot(song_note(SONG_DOREMI, int'(step_q)));
   assign last_step_d  = (int'(step_q) == song_len(song_q) - 1);

   // Outputs are registered from the current state, so note lags the state by
   // one cycle uniformly and every auto-play note keeps its full duration.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         song_q    <= SONG_ODE;
         step_q    <= '0;
         cnt_q     <= '0;
         armed_q   <= 1'b1;
         note_q    <= NOTE_REST;
         led_q     <= 8'h00;
         done_q    <= 1'b0;
         mistake_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         mistake_q <= 1'b0;
         if (sw == 8'h00) armed_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               note_q <= sw_decode(sw);
               led_q  <= 8'h00;
               if (ode_rise) begin
                  song_q  <= SONG_ODE;
                  state_q <= S_PLAY;
                  step_q  <= '0;
                  cnt_q   <= '0;
               end else if (dra_rise) begin
                  song_q  <= SONG_DOREMI;
                  state_q <= S_PLAY;
                  step_q  <= '0;
                  cnt_q   <= '0;
               end else if (drl_rise) begin
                  song_q  <= SONG_DOREMI;
                  state_q <= S_LEARN;
                  step_q  <= '0;
                  cnt_q   <= '0;
               end
            end

            S_PLAY: begin
               note_q <= play_note_d;
               led_q  <= 8'h00;
               if (cnt_q == NOTE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_GAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_GAP: begin
               note_q <= NOTE_REST;
               led_q  <= 8'h00;
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (last_step_d) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     step_q  <= step_q + 1'b1;
                     state_q <= S_PLAY;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_LEARN: begin
               note_q <= sw_decode(sw);
               led_q  <= learn_hint_d;
               // One judgement per key press; the player must release all keys to re-arm.
               if (sw != 8'h00 && armed_q) begin
                  armed_q <= 1'b0;
                  if (sw == learn_hint_d) begin
                     if (last_step_d) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                     end else begin
                        step_q <= step_q + 1'b1;
                     end
                  end else begin
                     mistake_q <= 1'b1;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign note      = note_q;
   assign Led       = led_q;
   assign step      = step_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign mistake   = mistake_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: free play, auto-play, learn mode and
// mid-song reset, with note/done/mistake events checked through a queue.
module tb_song_sequencer;
   import piano_pkg::*;

   localparam int NT = 4;
   localparam int GT = 2;
   localparam int IW = 5;
   localparam int ODE_SPAN = 15 * (NT + GT);

   localparam logic [7:0] EV_DONE = 8'h40;
   localparam logic [7:0] EV_MISS = 8'h80;

   localparam logic [3:0] ODE_TAB [15] = '{4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2,
                                            4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2};
   localparam logic [7:0] DRM_SW  [7]  = '{8'h80, 8'h40, 8'h20, 8'h80, 8'h20, 8'h80, 8'h20};
   localparam logic [3:0] DRM_NOTE[7]  = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd3, 4'd1, 4'd3};

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          ode = 1'b0;
   logic          dra = 1'b0;
   logic          drl = 1'b0;
   logic [7:0]    sw  = 8'h00;
   logic [3:0]    note;
   logic [7:0]    led;
   logic [IW-1:0] step;
   logic          busy;
   logic          done;
   logic          mistake;
   logic [1:0]    dbg_state;

   song_sequencer #(
      .NOTE_TICKS (NT),
      .GAP_TICKS  (GT),
      .IDX_W      (IW)
   ) dut (
      .CLK             (clk),
      .RESET           (rst),
      .ODE_TO_JOY_AUTO (ode),
      .DOREMI_AUTO     (dra),
      .DOREMI_LEARN    (drl),
      .sw              (sw),
      .note            (note),
      .Led             (led),
      .step            (step),
      .busy            (busy),
      .done            (done),
      .mistake         (mistake),
      .dbg_state       (dbg_state)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       watch_play = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input logic [7:0] got);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected: got %0h expected none", got);
      end else begin
         e = exp_q.pop_front();
         check("sb_event", 32'(got), 32'(e));
      end
   endtask

   task automatic wait_drain(input int limit, input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d events outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // driver tasks
   task automatic press(input logic [7:0] v);
      sw = v;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic release_keys();
      sw = 8'h00;
      @(negedge clk);
      @(negedge clk);
   endtask

   // monitor: pops the scoreboard on note starts, done and mistake pulses
   logic [3:0] prev_note = 4'd0;
   int         run_len   = 0;
   int         zero_len  = 0;
   int         cyc       = 0;
   int         first_cyc = 0;
   bit         seen      = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (done) begin
         sb_pop(EV_DONE);
         if (watch_play && seen) check("done_latency", 32'(cyc - first_cyc), 32'(ODE_SPAN - 1));
      end
      if (mistake) sb_pop(EV_MISS);
      if (!watch_play) begin
         seen     = 1'b0;
         run_len  = 0;
         zero_len = 0;
      end else if (note != 4'd0 && prev_note == 4'd0) begin
         sb_pop({4'h0, note});
         if (seen) check("gap_len", 32'(zero_len), 32'(GT));
         else first_cyc = cyc;
         seen    = 1'b1;
         run_len = 1;
      end else if (note != 4'd0) begin
         run_len++;
      end else if (prev_note != 4'd0) begin
         if (seen) check("note_len", 32'(run_len), 32'(NT));
         zero_len = 1;
      end else begin
         zero_len++;
      end
      prev_note = note;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset and free play
      repeat (5) @(posedge clk);
      #1;
      check("rst_note", 32'(note), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      check("rst_pulses", 32'({done, mistake}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_note", 32'(note), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_state", 32'(dbg_state), 32'(S_IDLE));
      sw = 8'h20; @(negedge clk); check("free_e", 32'(note), 32'd3);
      sw = 8'h22; @(negedge clk); check("free_prio", 32'(note), 32'd3);
      sw = 8'h01; @(negedge clk); check("free_c2", 32'(note), 32'd8);
      sw = 8'hFF; @(negedge clk); check("free_all", 32'(note), 32'd1);
      sw = 8'h00; @(negedge clk); check("free_rest", 32'(note), 32'd0);
      check("free_led", 32'(led), 32'd0);

      // Ode auto-play started by a bouncing button
      watch_play = 1'b1;
      for (int i = 0; i < 15; i++) exp_q.push_back({4'h0, ODE_TAB[i]});
      exp_q.push_back(EV_DONE);
      for (int j = 0; j < 5; j++) begin
         ode = (j % 2 == 0);
         @(negedge clk);
      end
      ode = 1'b0;
      wait_drain(ODE_SPAN + 20, "ode_song_timeout");
      check("ode_end_busy", 32'(busy), 32'd0);
      watch_play = 1'b0;
      repeat (10) @(negedge clk);
      check("ode_no_restart", 32'(busy), 32'd0);

      // simultaneous starts, ignored edge mid-song, then reset at step 5
      for (int i = 0; i < 6; i++) exp_q.push_back({4'h0, ODE_TAB[i]});
      watch_play = 1'b1;
      ode = 1'b1;
      dra = 1'b1;
      for (int k = 0; k <= 31; k++) begin
         @(negedge clk);
         if (k == 10) dra = 1'b0;
         if (k == 12) dra = 1'b1;
         if (k == 0 || k == 6 || k == 13 || k == 24 || k == 31)
            check("play_step", 32'(step), 32'(k / 6));
         if (k == 31) check("play_note5", 32'(note), 32'd4);
      end
      #2;
      watch_play = 1'b0;
      ode = 1'b0;
      dra = 1'b0;
      rst = 1'b1;
      #1;
      check("async_note", 32'(note), 32'd0);
      check("async_step", 32'(step), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("ode_prefix_events", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sw = 8'h10;
      @(negedge clk);
      check("post_rst_free", 32'(note), 32'd4);
      check("post_rst_busy", 32'(busy), 32'd0);
      sw = 8'h00;
      @(negedge clk);

      // learn mode, full lesson
      drl = 1'b1;
      @(negedge clk);
      drl = 1'b0;
      @(negedge clk);
      check("learn_led0", 32'(led), 32'h80);
      check("learn_step0", 32'(step), 32'd0);
      check("learn_state", 32'(dbg_state), 32'(S_LEARN));
      for (int i = 0; i < 7; i++) begin
         if (i == 6) exp_q.push_back(EV_DONE);
         press(DRM_SW[i]);
         if (i < 6) begin
            check("learn_step", 32'(step), 32'(i + 1));
            check("learn_led", 32'(led), 32'(DRM_SW[i + 1]));
            check("learn_note", 32'(note), 32'(DRM_NOTE[i]));
         end else begin
            check("learn_end_busy", 32'(busy), 32'd0);
            check("learn_end_led", 32'(led), 32'd0);
         end
         release_keys();
      end
      wait_drain(5, "learn_done");

      // learn mode mistakes
      drl = 1'b1;
      @(negedge clk);
      drl = 1'b0;
      @(negedge clk);
      press(8'h80);
      check("miss_pre_step", 32'(step), 32'd1);
      release_keys();
      exp_q.push_back(EV_MISS);
      press(8'h10);
      check("miss_hold_step", 32'(step), 32'd1);
      repeat (5) @(negedge clk);
      check("miss_held_step", 32'(step), 32'd1);
      release_keys();
      press(8'h40);
      check("miss_recover", 32'(step), 32'd2);
      release_keys();
      exp_q.push_back(EV_MISS);
      press(8'h30);
      check("miss_multi", 32'(step), 32'd2);
      release_keys();
      wait_drain(5, "learn_mistakes");
      check("miss_still_busy", 32'(busy), 32'd1);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
